// File: rtl/fetch_sequencer.sv
// Control-unit fetch sequencer: walks the two-byte instruction fetch (IR0, IR1)
// over the control bus, hands off to execute, then re-fetches, idles or halts.
module fetch_sequencer #(
    parameter int ID_WIDTH    = 5,
    parameter int AMID_WIDTH  = 2,
    parameter int MEM_ID      = 4,
    parameter int IR0_ID      = 0,
    parameter int IR1_ID      = 1,
    parameter int PC_AMID     = 0,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   run,
    input  logic                   exec_done,
    input  logic                   halt_req,
    output logic [AMID_WIDTH-1:0]  amid,
    output logic [ID_WIDTH-1:0]    mid,
    output logic [ID_WIDTH-1:0]    sid,
    output logic                   mid_en,
    output logic                   sid_en,
    output logic                   pc_inr,
    output logic                   exec_start,
    output logic                   halted,
    output logic [2:0]             t_state,
    output logic [COUNT_WIDTH-1:0] instr_count
);

    localparam logic [2:0] S_T0   = 3'd0;
    localparam logic [2:0] S_T1   = 3'd1;
    localparam logic [2:0] S_T2   = 3'd2;
    localparam logic [2:0] S_T3   = 3'd3;
    localparam logic [2:0] S_EXEC = 3'd4;
    localparam logic [2:0] S_IDLE = 3'd6;
    localparam logic [2:0] S_HALT = 3'd7;

    logic [2:0]             state;
    logic [2:0]             state_next;
    logic                   first_exec;
    logic [COUNT_WIDTH-1:0] count;
    logic                   exec_exit;

    assign exec_exit = (state == S_EXEC) && exec_done;

    always_comb begin
        state_next = S_IDLE;
        case (state)
            S_IDLE: state_next = run ? S_T0 : S_IDLE;
            S_T0:   state_next = S_T1;
            S_T1:   state_next = S_T2;
            S_T2:   state_next = S_T3;
            S_T3:   state_next = S_EXEC;
            S_EXEC: begin
                if (!exec_done)
                    state_next = S_EXEC;
                else if (halt_req)
                    state_next = S_HALT;
                else if (run)
                    state_next = S_T0;
                else
                    state_next = S_IDLE;
            end
            S_HALT: state_next = S_HALT;
            default: state_next = S_IDLE;
        endcase
    end

    // first_exec marks the cycle right after T3 so exec_start pulses once per instruction
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            first_exec <= 1'b0;
            count      <= '0;
        end else begin
            state      <= state_next;
            first_exec <= (state == S_T3);
            if (exec_exit)
                count <= count + COUNT_WIDTH'(1);
        end
    end

    always_comb begin
        amid       = '0;
        mid        = '0;
        sid        = '0;
        mid_en     = 1'b0;
        sid_en     = 1'b0;
        pc_inr     = 1'b0;
        exec_start = 1'b0;
        halted     = 1'b0;
        case (state)
            S_T0, S_T1, S_T2, S_T3: begin
                amid   = AMID_WIDTH'(PC_AMID);
                mid    = ID_WIDTH'(MEM_ID);
                mid_en = 1'b1;
                sid    = (state == S_T3) ? ID_WIDTH'(IR1_ID) : ID_WIDTH'(IR0_ID);
                sid_en = (state == S_T1) || (state == S_T3);
                pc_inr = (state == S_T1) || (state == S_T3);
            end
            S_EXEC: exec_start = first_exec;
            S_HALT: halted = 1'b1;
            default: ;
        endcase
    end

    assign t_state     = state;
    assign instr_count = count;

endmodule
